// File: rtl/tx_uart_ctrl_pkg.sv
// Shared definitions for the UART transmit controller: FSM state encoding,
// default bus addresses and the layout of the status word.
// Ports: none (package).
package tx_uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [31:0] TX_ADDR_DEF   = 32'd1044;
  localparam logic [31:0] STAT_ADDR_DEF = 32'd1048;

  // Status word as seen at the status address; busy is bit 0.
  typedef struct packed {
    logic [26:0] rsvd;
    logic        overflow;
    logic        fifo_full;
    logic        fifo_empty;
    logic        line_active;
    logic        busy;
  } stat_t;

endpackage

// File: rtl/tx_fifo.sv
// Purpose: synchronous byte FIFO feeding the UART serializer.
// Latency: push visible at dout/empty one edge later; head is read combinationally.
// Backpressure: push on full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
// Ports: clk/reset, push+din write side, pop+dout read side, full/empty flags.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, the write slot is the head being popped this same edge, so the
  // overwrite is safe: the old head has already been read combinationally.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tx_uart_ctrl.sv
// Purpose: memory-mapped UART TX; CPU stores are queued and sent as 8N1 frames.
// Latency: start bit begins one cycle after the push edge; a frame is 10*CLK_DIV cycles.
// Backpressure: none toward the CPU; a store to a full FIFO is dropped and sets sticky overflow.
// Ports: clk/reset; addr, DM_W, wdata from the data-memory bus; rdata status
// readback (combinational); txd serial line (registered, idle high); busy.
module tx_uart_ctrl
  import tx_uart_ctrl_pkg::*;
#(
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] TX_ADDR    = TX_ADDR_DEF,
  parameter logic [31:0] STAT_ADDR  = STAT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        DM_W,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        busy
);

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  logic        wr_hit, wr_hit_q, push;
  logic        clr_hit, clr_hit_q, clr;
  logic        fifo_full, fifo_empty, pop;
  logic [7:0]  fifo_dout;
  logic        overflow, ovf_set;
  logic        line_active;
  logic        bit_end;
  tx_state_e   state, state_nxt;
  logic [15:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [7:0]  shifter, shifter_nxt;
  logic        txd_nxt;
  stat_t       stat;
  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^wdata[31:8];

  // A held store is one strobe: act only on the first cycle of each run.
  assign wr_hit  = DM_W && (addr == TX_ADDR);
  assign clr_hit = DM_W && (addr == STAT_ADDR);
  assign push    = wr_hit && !wr_hit_q;
  assign clr     = clr_hit && !clr_hit_q;
  assign ovf_set = push && fifo_full && !pop;

  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign line_active = (state != IDLE);
  assign busy        = line_active || !fifo_empty;
  assign bit_end     = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nxt   = state;
    baud_nxt    = bit_end ? 16'd0 : baud_cnt + 16'd1;
    bit_nxt     = bit_cnt;
    shifter_nxt = shifter;
    pop         = 1'b0;
    unique case (state)
      IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
        if (!fifo_empty) begin
          pop         = 1'b1;
          shifter_nxt = fifo_dout;
          state_nxt   = START;
        end
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shifter_nxt = {1'b0, shifter[7:1]};
          bit_nxt     = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit so frames abut.
          if (!fifo_empty) begin
            pop         = 1'b1;
            shifter_nxt = fifo_dout;
            bit_nxt     = '0;
            state_nxt   = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // txd is registered from the next state so the line changes on the
    // same edge as the state it belongs to.
    unique case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shifter_nxt[0];
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shifter   <= '0;
      txd       <= 1'b1;
      overflow  <= 1'b0;
      wr_hit_q  <= 1'b0;
      clr_hit_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shifter   <= shifter_nxt;
      txd       <= txd_nxt;
      wr_hit_q  <= wr_hit;
      clr_hit_q <= clr_hit;
      // A new overflow outranks a clear in the same cycle.
      if (ovf_set)  overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

  always_comb begin
    stat             = '0;
    stat.overflow    = overflow;
    stat.fifo_full   = fifo_full;
    stat.fifo_empty  = fifo_empty;
    stat.line_active = line_active;
    stat.busy        = busy;
    rdata            = (addr == STAT_ADDR) ? stat : '0;
  end

endmodule
